// File: rtl/fpu_div_seq.sv
// fpu_div_seq: multi-cycle IEEE-754 single-precision divider (FPU op 5).
// Restoring quotient loop; round-to-nearest-even; subnormals flushed to zero.
// Ports: clk, rst (async active-low), start/i_signed/input_a/input_b in;
//        o_busy, o_valid, o_err, o_output[31:0],
//        o_flags[3:0] = {invalid, div0, overflow, inexact} out.
// Option: define FPU_DIV_RADIX4_EN to retire 2 quotient bits per cycle.
module fpu_div_seq #(
  parameter logic [2:0] OP_DIV = 3'd5,
  parameter int         QBITS  = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  i_signed,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  output logic        o_busy,
  output logic        o_valid,
  output logic        o_err,
  output logic [31:0] o_output,
  output logic [3:0]  o_flags
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_DIV, S_ROUND, S_DONE
  } state_t;

`ifdef FPU_DIV_RADIX4_EN
  localparam logic [4:0] LAST = 5'(QBITS / 2 - 1);
`else
  localparam logic [4:0] LAST = 5'(QBITS - 1);
`endif

  state_t             state_q;
  logic [31:0]        a_q, b_q;
  logic [2:0]         op_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        mb_q;
  logic [25:0]        rem_q;
  logic [QBITS-1:0]   quo_q;
  logic [4:0]         cnt_q;
  logic               byp_q;
  logic [31:0]        sres_q;
  logic [3:0]         sflg_q;
  logic               serr_q;

  // One restoring step: {quotient bit, next shifted remainder}.
  function automatic logic [26:0] div_step(
    input logic [25:0] rem,
    input logic [23:0] d
  );
    logic        ge;
    logic [25:0] diff;
    ge   = rem >= {2'b00, d};
    diff = ge ? rem - {2'b00, d} : rem;
    return {ge, diff[24:0], 1'b0};
  endfunction

  // Unpack / special-case classification.
  logic              a_nan, a_inf, a_zro;
  logic              b_nan, b_inf, b_zro;
  logic              sgn_d, spc_d, serr_d;
  logic [31:0]       sres_d;
  logic [3:0]        sflg_d;
  logic signed [9:0] exp_un_d;

  always_comb begin
    a_nan = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    a_inf = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    a_zro = (a_q[30:23] == 8'h00);
    b_nan = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    b_inf = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    b_zro = (b_q[30:23] == 8'h00);
    sgn_d = a_q[31] ^ b_q[31];
    exp_un_d = $signed({2'b00, a_q[30:23]})
             - $signed({2'b00, b_q[30:23]})
             + 10'sd127;
    spc_d  = 1'b1;
    serr_d = 1'b0;
    sres_d = 32'd0;
    sflg_d = 4'd0;
    if (op_q != OP_DIV) begin
      serr_d = 1'b1;
    end else if (a_nan || b_nan || (a_zro && b_zro)
                 || (a_inf && b_inf)) begin
      sres_d = 32'h7FC0_0000;
      sflg_d = 4'b1000;
    end else if (a_inf) begin
      sres_d = {sgn_d, 8'hFF, 23'd0};
    end else if (b_zro) begin
      sres_d = {sgn_d, 8'hFF, 23'd0};
      sflg_d = 4'b0100;
    end else if (b_inf || a_zro) begin
      sres_d = {sgn_d, 31'd0};
    end else begin
      spc_d = 1'b0;
    end
  end

  // Quotient loop next state.
  logic [25:0]      rem_d;
  logic [QBITS-1:0] quo_d;

`ifdef FPU_DIV_RADIX4_EN
  logic [26:0] st1, st2;
  always_comb begin
    st1   = div_step(rem_q, mb_q);
    st2   = div_step(st1[25:0], mb_q);
    rem_d = st2[25:0];
    quo_d = {quo_q[QBITS-3:0], st1[26], st2[26]};
  end
`else
  logic [26:0] st1;
  always_comb begin
    st1   = div_step(rem_q, mb_q);
    rem_d = st1[25:0];
    quo_d = {quo_q[QBITS-2:0], st1[26]};
  end
`endif

  // Normalise, round to nearest even, range check.
  logic              norm, g, r, s, up, cy;
  logic [22:0]       frac_pre, frac_r;
  logic signed [9:0] exp_n, exp_r;
  logic [31:0]       res_d;
  logic [3:0]        flg_d;

  always_comb begin
    norm     = quo_q[QBITS-1];
    frac_pre = norm ? quo_q[QBITS-2 -: 23] : quo_q[QBITS-3 -: 23];
    g        = norm ? quo_q[QBITS-25] : quo_q[QBITS-26];
    r        = norm ? quo_q[QBITS-26] : 1'b0;
    s        = |rem_q;
    exp_n    = norm ? exp_q : exp_q - 10'sd1;
    up       = g & (r | s | frac_pre[0]);
    {cy, frac_r} = {1'b0, frac_pre} + 24'(up);
    exp_r    = cy ? exp_n + 10'sd1 : exp_n;
    res_d    = {sign_q, exp_r[7:0], frac_r};
    flg_d    = {3'b000, g | r | s};
    if (exp_r >= 10'sd255) begin
      res_d = {sign_q, 8'hFF, 23'd0};
      flg_d = 4'b0011;
    end else if (exp_r <= 10'sd0) begin
      res_d = {sign_q, 31'd0};
      flg_d = 4'b0001;
    end
    if (byp_q) begin
      res_d = sres_q;
      flg_d = sflg_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mb_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      byp_q    <= 1'b0;
      sres_q   <= '0;
      sflg_q   <= '0;
      serr_q   <= 1'b0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
      o_output <= '0;
      o_flags  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= input_a;
            b_q     <= input_b;
            op_q    <= i_signed;
            o_busy  <= 1'b1;
            state_q <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_q <= sgn_d;
          exp_q  <= exp_un_d;
          mb_q   <= {1'b1, b_q[22:0]};
          rem_q  <= {3'b001, a_q[22:0]};
          quo_q  <= '0;
          cnt_q  <= '0;
          byp_q  <= spc_d;
          sres_q <= sres_d;
          sflg_q <= sflg_d;
          serr_q <= serr_d;
          // Specials pass through ROUND so they share its output step.
          state_q <= spc_d ? S_ROUND : S_DIV;
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST) state_q <= S_ROUND;
        end
        S_ROUND: begin
          o_output <= res_d;
          o_flags  <= flg_d;
          o_err    <= byp_q & serr_q;
          o_valid  <= 1'b1;
          o_busy   <= 1'b0;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (!start) begin
            o_valid <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_seq.sv
// tb_fpu_div_seq: randomized check of fpu_div_seq against an
// arithmetic reference model (exact integer division + RNE).
module tb_fpu_div_seq;

`ifdef FPU_DIV_RADIX4_EN
  localparam int LAT_N = 15;
`else
  localparam int LAT_N = 28;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  i_signed;
  logic [31:0] input_a, input_b;
  logic        o_busy, o_valid, o_err;
  logic [31:0] o_output;
  logic [3:0]  o_flags;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_div_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .i_signed (i_signed),
    .input_a  (input_a),
    .input_b  (input_b),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_err    (o_err),
    .o_output (o_output),
    .o_flags  (o_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {normal_path, err, flags[3:0], result[31:0]}.
  function automatic logic [37:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [2:0] op);
    int ea, eb, e, sh;
    logic s, an, ai, az, bn, bi, bz, inx, upr;
    longint unsigned ma, mb, q, rm, mant, drop, half;
    if (op != 3'd5) return {1'b0, 1'b1, 4'd0, 32'd0};
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = (eb == 0);
    s  = a[31] ^ b[31];
    if (an || bn || (az && bz) || (ai && bi))
      return {1'b0, 1'b0, 4'b1000, 32'h7FC0_0000};
    if (ai) return {1'b0, 1'b0, 4'b0000, s, 8'hFF, 23'd0};
    if (bz) return {1'b0, 1'b0, 4'b0100, s, 8'hFF, 23'd0};
    if (bi || az) return {1'b0, 1'b0, 4'b0000, s, 31'd0};
    ma = 64'(a[22:0]) + (64'd1 << 23);
    mb = 64'(b[22:0]) + (64'd1 << 23);
    q  = (ma << 30) / mb;
    rm = (ma << 30) % mb;
    e  = ea - eb + 127;
    if (q >= (64'd1 << 30)) sh = 7;
    else begin
      sh = 6;
      e  = e - 1;
    end
    mant = q >> sh;
    drop = q & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    inx  = (drop != 0) || (rm != 0);
    upr  = (drop > half)
        || (drop == half && (rm != 0 || mant[0]));
    if (upr) mant = mant + 1;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e = e + 1;
    end
    if (e >= 255) return {1'b1, 1'b0, 4'b0011, s, 8'hFF, 23'd0};
    if (e <= 0) return {1'b1, 1'b0, 4'b0001, s, 31'd0};
    return {1'b1, 1'b0, 3'b000, inx, s, 8'(e), mant[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input string tag);
    logic [37:0] e;
    int n;
    e = ref_div(a, b, op);
    @(negedge clk);
    input_a  = a;
    input_b  = b;
    i_signed = op;
    start    = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) chk({tag, ":busy"}, 32'(o_busy), 32'd1);
    end while (!o_valid && n < 200);
    chk({tag, ":lat"}, n - 1, e[37] ? LAT_N : 2);
    chk({tag, ":out"}, o_output, e[31:0]);
    chk({tag, ":flg"}, 32'(o_flags), 32'(e[35:32]));
    chk({tag, ":err"}, 32'(o_err), 32'(e[36]));
    input_a = $urandom;
    input_b = $urandom;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ":hold_v"}, 32'(o_valid), 32'd1);
    chk({tag, ":hold_b"}, 32'(o_busy), 32'd0);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ":drop_v"}, 32'(o_valid), 32'd0);
    chk({tag, ":kept"}, o_output, e[31:0]);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] spc [8];
    spc = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
            32'hFF80_0000, 32'h7FC0_0000, 32'h0000_1234,
            32'h3F80_0000, 32'h7F7F_FFFF};
    if ($urandom_range(0, 7) == 0) return spc[$urandom_range(0, 7)];
    return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    i_signed = 3'd0;
    input_a  = '0;
    input_b  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst:busy", 32'(o_busy), 32'd0);
    chk("rst:valid", 32'(o_valid), 32'd0);
    chk("rst:err", 32'(o_err), 32'd0);
    chk("rst:out", o_output, 32'd0);
    chk("rst:flg", 32'(o_flags), 32'd0);
    rst = 1'b1;

    run_op(32'h4170_0000, 32'h4040_0000, 3'd5, "15/3");
    chk("15/3:val", o_output, 32'h40A0_0000);
    run_op(32'h3F80_0000, 32'h4040_0000, 3'd5, "1/3");
    chk("1/3:val", o_output, 32'h3EAA_AAAB);
    run_op(32'h4080_0000, 32'h4000_0000, 3'd5, "4/2");
    run_op(32'h3F80_0000, 32'h0000_0000, 3'd5, "1/0");
    chk("1/0:flg", 32'(o_flags), 32'h4);
    run_op(32'h0000_0000, 32'h0000_0000, 3'd5, "0/0");
    run_op(32'hC2C8_0000, 32'h0000_0000, 3'd5, "-100/0");
    run_op(32'h7F00_0000, 32'h3E80_0000, 3'd5, "ovf");
    chk("ovf:val", o_output, 32'h7F80_0000);
    run_op(32'h0080_0000, 32'h4B00_0000, 3'd5, "unf");
    run_op(32'h4170_0000, 32'h4040_0000, 3'd0, "badop");
    chk("badop:errv", 32'(o_err), 32'd1);
    run_op(32'h7F80_0000, 32'hC000_0000, 3'd5, "inf/-2");
    run_op(32'h4000_0000, 32'h7F80_0000, 3'd5, "2/inf");

    for (int i = 0; i < 40; i++)
      run_op(rnd_fp(), rnd_fp(), ($urandom_range(0, 9) == 0)
             ? 3'($urandom_range(0, 4)) : 3'd5, $sformatf("rnd%0d", i));

    // Reset in the middle of the quotient loop.
    @(negedge clk);
    input_a  = 32'h4170_0000;
    input_b  = 32'h4040_0000;
    i_signed = 3'd5;
    start    = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid:busy", 32'(o_busy), 32'd0);
    chk("mid:valid", 32'(o_valid), 32'd0);
    chk("mid:out", o_output, 32'd0);
    chk("mid:flg", 32'(o_flags), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid:idle", 32'(o_busy), 32'd0);
    run_op(32'h4080_0000, 32'h4000_0000, 3'd5, "after_rst");
    chk("after_rst:val", o_output, 32'h4000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
